telemetry_framer: RTL

Parametrised packetiser between the sensor register bank and the downlink serial transmitter. It snapshots NUM_CH channels of CH_BYTES bytes each, either periodically or on request. It emits a framed byte stream (sync, sequence, length, payload, check byte) through the serial_tx new_data/busy/block handshake. It generalises fixed-format downlink formatting to any channel count and channel width.

---
 rtl/telemetry_framer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/telemetry_framer.sv
// Snapshots NUM_CH x CH_BYTES channel words on a periodic tick or trigger and streams
// SYNC0 SYNC1 seq LEN payload CHK to serial_tx; define FRAMER_CRC8_EN for a CRC-8 check byte.
module telemetry_framer #(
    parameter int         NUM_CH        = 12,
    parameter int         CH_BYTES      = 2,
    parameter int         PERIOD_CYCLES = 500000,
    parameter logic [7:0] SYNC0         = 8'hAA,
    parameter logic [7:0] SYNC1         = 8'h55
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         trigger,
    input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data,
    input  logic                         tx_busy,
    input  logic                         tx_block,
    output logic [7:0]                   tx_data,
    output logic                         new_tx_data,
    output logic                         frame_active,
    output logic [7:0]                   seq,
    output logic [7:0]                   overrun_cnt
);
    localparam int            LEN      = NUM_CH * CH_BYTES;
    localparam int            NBYTES   = LEN + 5;
    localparam int            IW       = $clog2(NBYTES);
    localparam int            CW       = $clog2(PERIOD_CYCLES);
    localparam logic [7:0]    LEN_B    = 8'(LEN);
    localparam logic [IW-1:0] IDX_SEQ  = IW'(2);
    localparam logic [IW-1:0] IDX_PAY0 = IW'(4);
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_HOLD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    period_cnt;
    logic             tick;
    logic             req;
    logic             start;
    logic             issue;
    logic             advance;
    logic             finish;
    logic [IW-1:0]    idx;
    logic [LEN*8-1:0] snap;
    logic [LEN*8-1:0] snap_in;
    logic [7:0]       chk;
    logic [7:0]       cur_byte;
    logic             in_payload;
    logic             in_chk_span;

    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef FRAMER_CRC8_EN
        logic [7:0] c;
        c = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
`else
        return acc ^ b;
`endif
    endfunction

    // Free-running period counter, independent of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (period_cnt == CNT_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    assign tick = (period_cnt == CNT_LAST);
    assign req  = tick | trigger;

    // Snapshot is stored in wire order so the payload is always shifted out of the top byte.
    always_comb begin
        snap_in = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < CH_BYTES; b++) begin
                snap_in[(LEN - 1 - (c * CH_BYTES + b)) * 8 +: 8] =
                    ch_data[(c * CH_BYTES + (CH_BYTES - 1 - b)) * 8 +: 8];
            end
        end
    end

    always_comb begin
        in_payload  = (idx >= IDX_PAY0) && (idx < IDX_LAST);
        in_chk_span = (idx >= IDX_SEQ) && (idx < IDX_LAST);
        cur_byte    = snap[LEN*8-1 -: 8];
        if (idx == IW'(0)) begin
            cur_byte = SYNC0;
        end else if (idx == IW'(1)) begin
            cur_byte = SYNC1;
        end else if (idx == IDX_SEQ) begin
            cur_byte = seq;
        end else if (idx == IW'(3)) begin
            cur_byte = LEN_B;
        end else if (idx == IDX_LAST) begin
            cur_byte = chk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        issue     = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req && enable) begin
                    start     = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy && !tx_block) begin
                    issue     = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            // serial_tx raises busy a cycle after the strobe, so busy is not trusted here.
            S_HOLD: state_nxt = S_WAIT;
            S_WAIT: begin
                if (!tx_busy) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = S_SEND;
                    end
                end
            end
            S_DONE: begin
                finish    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data      <= 8'h00;
            new_tx_data  <= 1'b0;
            frame_active <= 1'b0;
            seq          <= 8'h00;
            overrun_cnt  <= 8'h00;
            idx          <= '0;
            snap         <= '0;
            chk          <= 8'h00;
        end else begin
            new_tx_data <= issue;
            if (issue) begin
                tx_data <= cur_byte;
            end
            if (start) begin
                snap         <= snap_in;
                idx          <= '0;
                chk          <= 8'h00;
                frame_active <= 1'b1;
            end else if (issue && in_payload) begin
                snap <= snap << 8;
            end
            if (issue && in_chk_span) begin
                chk <= chk_step(chk, cur_byte);
            end
            if (advance) begin
                idx <= idx + 1'b1;
            end
            if (finish) begin
                frame_active <= 1'b0;
                seq          <= seq + 1'b1;
            end
            if (req && frame_active && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end
endmodule
